// File: rtl/mdio_phy_clause22.sv
// Clause 22 MDIO PHY-side responder.
// mdc and mdio are oversampled through 2-FF synchronisers. Frames are decoded on
// mdc rising edges, and the open-drain drive changes only after mdc falling edges.
// Writes land in a 32 x 16 register bank and are announced through reg_wr.
// Registers 2 and 3 hold fixed PHY identifiers.
module mdio_phy_clause22 #(
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622,
    parameter int          MIN_PREAMBLE = 32
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [4:0]  phy_addr,
    input  logic        mdc,
    inout  wire         mdio,
    output logic        reg_wr,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        rd_strobe,
    output logic        frame_err,
    output logic        busy
);

    localparam int PRE_W = $clog2(MIN_PREAMBLE + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MIN_PREAMBLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST2,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_END
    } state_t;

    // Synchroniser and edge-detect registers.
    logic mdc_s1_reg, mdc_s2_reg, mdc_prev_reg;
    logic mdio_s1_reg, mdio_s2_reg;
    logic mdc_rise, mdc_fall, bit_in;

    // Frame decode state.
    state_t            state_reg,   state_next;
    logic [PRE_W-1:0]  pre_cnt_reg, pre_cnt_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic              op_first_reg, op_first_next;
    logic              is_read_reg, is_read_next;
    logic              match_reg,   match_next;
    logic [3:0]        phyad_reg,   phyad_next;
    logic [4:0]        regad_reg,   regad_next;
    logic [15:0]       shift_reg,   shift_next;
    logic              drive_low_reg, drive_low_next;

    // Registered outputs.
    logic              reg_wr_reg,    reg_wr_next;
    logic [4:0]        reg_addr_reg,  reg_addr_next;
    logic [15:0]       reg_wdata_reg, reg_wdata_next;
    logic              rd_strobe_reg, rd_strobe_next;
    logic              frame_err_reg, frame_err_next;

    // Register bank; entries 2 and 3 are constant identifiers.
    logic [15:0] bank_reg [32];

    // Bring mdc and mdio into the clk domain and keep the previous mdc for edge detection.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            mdc_s1_reg   <= 1'b0;
            mdc_s2_reg   <= 1'b0;
            mdc_prev_reg <= 1'b0;
            mdio_s1_reg  <= 1'b0;
            mdio_s2_reg  <= 1'b0;
        end else begin
            mdc_s1_reg   <= mdc;
            mdc_s2_reg   <= mdc_s1_reg;
            mdc_prev_reg <= mdc_s2_reg;
            mdio_s1_reg  <= mdio;
            mdio_s2_reg  <= mdio_s1_reg;
        end
    end

    assign mdc_rise = mdc_s2_reg & ~mdc_prev_reg;
    assign mdc_fall = ~mdc_s2_reg & mdc_prev_reg;
    assign bit_in   = mdio_s2_reg;

    // Open-drain output: pull low or release.
    assign mdio = drive_low_reg ? 1'b0 : 1'bz;

    // State register for the frame decoder and all registered outputs.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg     <= S_IDLE;
            pre_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            op_first_reg  <= 1'b0;
            is_read_reg   <= 1'b0;
            match_reg     <= 1'b0;
            phyad_reg     <= '0;
            regad_reg     <= '0;
            shift_reg     <= '0;
            drive_low_reg <= 1'b0;
            reg_wr_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            reg_wdata_reg <= '0;
            rd_strobe_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pre_cnt_reg   <= pre_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            op_first_reg  <= op_first_next;
            is_read_reg   <= is_read_next;
            match_reg     <= match_next;
            phyad_reg     <= phyad_next;
            regad_reg     <= regad_next;
            shift_reg     <= shift_next;
            drive_low_reg <= drive_low_next;
            reg_wr_reg    <= reg_wr_next;
            reg_addr_reg  <= reg_addr_next;
            reg_wdata_reg <= reg_wdata_next;
            rd_strobe_reg <= rd_strobe_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic. Frame bits are consumed on mdc_rise, and the drive moves on mdc_fall.
    always_comb begin
        state_next     = state_reg;
        pre_cnt_next   = pre_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        op_first_next  = op_first_reg;
        is_read_next   = is_read_reg;
        match_next     = match_reg;
        phyad_next     = phyad_reg;
        regad_next     = regad_reg;
        shift_next     = shift_reg;
        drive_low_next = drive_low_reg;
        reg_wr_next    = 1'b0;
        reg_addr_next  = reg_addr_reg;
        reg_wdata_next = reg_wdata_reg;
        rd_strobe_next = 1'b0;
        frame_err_next = 1'b0;

        if (mdc_fall) begin
            case (state_reg)
                // Second turnaround bit: take the line low for a matched read.
                S_TA: begin
                    if (is_read_reg && match_reg && bit_cnt_reg == 4'd1)
                        drive_low_next = 1'b1;
                end
                // Present the next read bit; a 1 is produced by releasing the line.
                S_DATA: begin
                    if (is_read_reg && match_reg) begin
                        drive_low_next = ~shift_reg[15];
                        shift_next     = {shift_reg[14:0], 1'b0};
                    end
                end
                S_END: begin
                    drive_low_next = 1'b0;
                    state_next     = S_IDLE;
                    pre_cnt_next   = '0;
                end
                default: ;
            endcase
        end else if (mdc_rise) begin
            case (state_reg)
                S_IDLE: begin
                    if (bit_in) begin
                        if (pre_cnt_reg < PRE_MAX)
                            pre_cnt_next = pre_cnt_reg + 1'b1;
                    end else if (pre_cnt_reg == PRE_MAX) begin
                        state_next   = S_ST2;
                        pre_cnt_next = '0;
                    end else begin
                        pre_cnt_next = '0;
                    end
                end
                S_ST2: begin
                    state_next   = bit_in ? S_OP : S_IDLE;
                    bit_cnt_next = '0;
                end
                S_OP: begin
                    if (bit_cnt_reg == 4'd0) begin
                        op_first_next = bit_in;
                        bit_cnt_next  = 4'd1;
                    end else begin
                        bit_cnt_next = '0;
                        case ({op_first_reg, bit_in})
                            2'b10: begin
                                is_read_next = 1'b1;
                                state_next   = S_PHYAD;
                            end
                            2'b01: begin
                                is_read_next = 1'b0;
                                state_next   = S_PHYAD;
                            end
                            default: state_next = S_IDLE;
                        endcase
                    end
                end
                S_PHYAD: begin
                    phyad_next   = {phyad_reg[2:0], bit_in};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 4'd4) begin
                        match_next   = ({phyad_reg, bit_in} == phy_addr);
                        bit_cnt_next = '0;
                        state_next   = S_REGAD;
                    end
                end
                S_REGAD: begin
                    regad_next   = {regad_reg[3:0], bit_in};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 4'd4) begin
                        bit_cnt_next = '0;
                        state_next   = S_TA;
                    end
                end
                S_TA: begin
                    if (bit_cnt_reg == 4'd0) begin
                        bit_cnt_next = 4'd1;
                        if (is_read_reg) begin
                            if (match_reg) begin
                                shift_next     = bank_reg[regad_reg];
                                rd_strobe_next = 1'b1;
                                reg_addr_next  = regad_reg;
                            end
                        end else if (!bit_in) begin
                            frame_err_next = match_reg;
                            state_next     = S_IDLE;
                        end
                    end else begin
                        bit_cnt_next = '0;
                        if (!is_read_reg && bit_in) begin
                            frame_err_next = match_reg;
                            state_next     = S_IDLE;
                        end else begin
                            state_next = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (!is_read_reg)
                        shift_next = {shift_reg[14:0], bit_in};
                    if (bit_cnt_reg == 4'd15) begin
                        state_next = S_END;
                        if (!is_read_reg && match_reg) begin
                            reg_wr_next    = 1'b1;
                            reg_addr_next  = regad_reg;
                            reg_wdata_next = {shift_reg[14:0], bit_in};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // One storage word per register. Writes commit during the reg_wr cycle.
    // Registers 2 and 3 are tied to the identifiers and ignore writes.
    for (genvar gi = 0; gi < 32; gi++) begin : g_bank
        if (gi == 2 || gi == 3) begin : g_ro
            localparam logic [15:0] RO_VAL = (gi == 2) ? PHY_ID1 : PHY_ID2;
            // Identifier registers hold their constant.
            always_ff @(posedge clk) begin
                bank_reg[gi] <= RO_VAL;
            end
        end else begin : g_rw
            // Writable register, cleared by reset.
            always_ff @(posedge clk) begin
                if (!arst_n)
                    bank_reg[gi] <= 16'h0000;
                else if (reg_wr_reg && reg_addr_reg == 5'(gi))
                    bank_reg[gi] <= reg_wdata_reg;
            end
        end
    end

    assign reg_wr    = reg_wr_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign rd_strobe = rd_strobe_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != S_IDLE) && (state_reg != S_ST2);

endmodule

// File: tb/tb_mdio_phy_clause22.sv
// Bench for mdio_phy_clause22. A station-master model drives directed frames.
// Expected DUT events and read-back words are queued by the stimulus.
// Independent monitors pop the queues and compare them against DUT activity.
module tb_mdio_phy_clause22;

    typedef struct packed {
        logic [2:0]  kind;   // {frame_err, rd_strobe, reg_wr}
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [4:0]  phy_addr;
    logic        mdc;
    logic        m_en;
    logic        m_val;
    wire         mdio;
    logic        reg_wr;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        rd_strobe;
    logic        frame_err;
    logic        busy;

    pullup (mdio);
    assign mdio = m_en ? m_val : 1'bz;

    mdio_phy_clause22 dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .phy_addr  (phy_addr),
        .mdc       (mdc),
        .mdio      (mdio),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .rd_strobe (rd_strobe),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    ev_t         exp_q[$];
    logic [17:0] rd_exp_q[$];
    logic [17:0] rd_got;
    event        rd_ev;
    int          tests_run = 0;
    int          fail_cnt  = 0;
    int          busy_cnt  = 0;
    ev_t         mon_got;
    ev_t         mon_exp;
    logic [17:0] rd_exp;
    logic [17:0] cap;
    int          b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Event monitor: every strobe from the DUT is matched against the next expected event.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (reg_wr || rd_strobe || frame_err) begin
            mon_got.kind = {frame_err, rd_strobe, reg_wr};
            if (exp_q.size() == 0) mon_exp = '0;
            else                   mon_exp = exp_q.pop_front();
            mon_got.addr = mon_exp.kind[2] ? 5'd0 : reg_addr;
            mon_got.data = mon_exp.kind[0] ? reg_wdata : 16'd0;
            $display("[TB] event kind=%b addr=%0d data=%h (expected kind=%b addr=%0d data=%h)",
                     mon_got.kind, mon_got.addr, mon_got.data,
                     mon_exp.kind, mon_exp.addr, mon_exp.data);
            check("dut event", {8'h0, mon_got}, {8'h0, mon_exp});
        end
    end

    // Read-back monitor: compares the TA and data bits seen by the master.
    initial begin
        forever begin
            @(rd_ev);
            if (rd_exp_q.size() == 0) rd_exp = 18'h0;
            else                      rd_exp = rd_exp_q.pop_front();
            $display("[TB] read  ta=%b data=%h (expected ta=%b data=%h)",
                     rd_got[17:16], rd_got[15:0], rd_exp[17:16], rd_exp[15:0]);
            check("read back", {14'h0, rd_got}, {14'h0, rd_exp});
        end
    end

    // One mdc period: mdc falls, the master updates the line, it samples, then mdc rises.
    task automatic do_bit(input logic en, input logic val, output logic smp);
        @(negedge clk);
        mdc   = 1'b0;
        m_en  = en;
        m_val = val;
        repeat (6) @(negedge clk);
        smp = mdio;
        mdc = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Full frame. If abort_at >= 0, a read is cut by a one-clk reset during that data bit.
    task automatic frame(input int npre, input logic rd, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [1:0] ta,
                         input logic [15:0] wdata, input int abort_at);
        logic        s;
        logic [13:0] hdr;
        logic [17:0] c;
        hdr = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra};
        c   = '0;
        for (int i = 0; i < npre; i++) do_bit(1'b1, 1'b1, s);
        for (int i = 13; i >= 0; i--) do_bit(1'b1, hdr[i], s);
        for (int i = 1; i >= 0; i--) begin
            if (rd) begin
                do_bit(1'b0, 1'b1, s);
                c[16 + i] = s;
            end else begin
                do_bit(1'b1, ta[i], s);
            end
        end
        for (int i = 15; i >= 0; i--) begin
            if (rd && i == abort_at) begin
                @(negedge clk);
                mdc  = 1'b0;
                m_en = 1'b0;
                repeat (6) @(negedge clk);
                check("t7 driven before reset", {31'h0, mdio}, 32'h0);
                arst_n = 1'b0;
                @(posedge clk);
                #1;
                check("t7 released after reset", {31'h0, mdio}, 32'h1);
                @(negedge clk);
                arst_n = 1'b1;
                check("t7 busy after reset", {31'h0, busy}, 32'h0);
                $display("[TB] frame aborted by reset at data bit %0d", i);
                repeat (8) @(negedge clk);
                return;
            end
            if (rd) begin
                do_bit(1'b0, 1'b1, s);
                c[i] = s;
            end else begin
                do_bit(1'b1, wdata[i], s);
            end
        end
        @(negedge clk);
        mdc  = 1'b0;
        m_en = 1'b0;
        repeat (8) @(negedge clk);
        cap = c;
        if (rd) begin
            rd_got = c;
            ->rd_ev;
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [15:0] d);
        exp_q.push_back({3'b001, a, d});
    endtask

    task automatic push_rd(input logic [4:0] a, input logic [15:0] d);
        exp_q.push_back({3'b010, a, 16'h0});
        rd_exp_q.push_back({2'b10, d});
    endtask

    initial begin
        arst_n   = 1'b0;
        mdc      = 1'b0;
        m_en     = 1'b0;
        m_val    = 1'b1;
        phy_addr = 5'd5;
        repeat (4) @(negedge clk);
        check("reset outputs", {9'h0, reg_wr, rd_strobe, frame_err, busy, reg_addr, reg_wdata}, 32'h0);
        check("reset mdio released", {31'h0, mdio}, 32'h1);
        arst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: write reg 4, then read it back
        push_wr(5'd4, 16'hA5C3);
        b0 = busy_cnt;
        frame(32, 1'b0, 5'd5, 5'd4, 2'b10, 16'hA5C3, -1);
        check("t1 busy seen", {31'h0, busy_cnt > b0}, 32'h1);
        push_rd(5'd4, 16'hA5C3);
        frame(32, 1'b1, 5'd5, 5'd4, 2'b00, 16'h0, -1);

        // 2: identifier register 2
        push_rd(5'd2, 16'h0022);
        frame(32, 1'b1, 5'd5, 5'd2, 2'b00, 16'h0, -1);

        // 3: write to read-only register 3 still strobes, but the bank keeps the ID
        push_wr(5'd3, 16'hFFFF);
        frame(32, 1'b0, 5'd5, 5'd3, 2'b10, 16'hFFFF, -1);
        push_rd(5'd3, 16'h1622);
        frame(32, 1'b1, 5'd5, 5'd3, 2'b00, 16'h0, -1);

        // 4: frames to another PHY are ignored; the next matching frame still works
        rd_exp_q.push_back({2'b11, 16'hFFFF});
        frame(32, 1'b1, 5'd6, 5'd4, 2'b00, 16'h0, -1);
        frame(32, 1'b0, 5'd6, 5'd4, 2'b10, 16'h0000, -1);
        push_rd(5'd4, 16'hA5C3);
        frame(32, 1'b1, 5'd5, 5'd4, 2'b00, 16'h0, -1);

        // 5: short preamble is rejected, full preamble accepted
        b0 = busy_cnt;
        frame(31, 1'b0, 5'd5, 5'd4, 2'b10, 16'h5A3C, -1);
        check("t5 busy idle on short preamble", busy_cnt - b0, 32'h0);
        push_wr(5'd4, 16'h5A3C);
        frame(32, 1'b0, 5'd5, 5'd4, 2'b10, 16'h5A3C, -1);

        // 6: bad turnaround on write -> frame_err, bank unchanged
        exp_q.push_back({3'b100, 5'd0, 16'h0});
        frame(32, 1'b0, 5'd5, 5'd4, 2'b00, 16'h1234, -1);
        push_rd(5'd4, 16'h5A3C);
        frame(32, 1'b1, 5'd5, 5'd4, 2'b00, 16'h0, -1);

        // 7: reset during read data bit 8 releases mdio and clears the bank
        push_wr(5'd4, 16'h00FF);
        frame(32, 1'b0, 5'd5, 5'd4, 2'b10, 16'h00FF, -1);
        exp_q.push_back({3'b010, 5'd4, 16'h0});
        frame(32, 1'b1, 5'd5, 5'd4, 2'b00, 16'h0, 8);
        push_rd(5'd4, 16'h0000);
        frame(32, 1'b1, 5'd5, 5'd4, 2'b00, 16'h0, -1);

        repeat (20) @(negedge clk);
        check("event queue drained", exp_q.size(), 32'h0);
        check("read queue drained", rd_exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
